// File: rtl/line_follow_sequencer_if.sv
// Sensor, plan-load and motor-drive signals of the line-follow sequencer.
// The sequencer takes the slave side; the stimulus/LFA side takes the master side.
interface line_follow_sequencer_if;
    logic        start;
    logic        sample_valid;
    logic [11:0] left;
    logic [11:0] middle;
    logic [11:0] right;
    logic        plan_wr_en;
    logic [3:0]  plan_wr_addr;
    logic [1:0]  plan_wr_data;
    logic        m1_a;
    logic        m1_b;
    logic        m2_a;
    logic        m2_b;
    logic [3:0]  dc1;
    logic [3:0]  dc2;
    logic [3:0]  node_count;
    logic        busy;
    logic        done;
    logic        fault;

    modport master (
        output start, sample_valid, left, middle, right,
               plan_wr_en, plan_wr_addr, plan_wr_data,
        input  m1_a, m1_b, m2_a, m2_b, dc1, dc2, node_count, busy, done, fault
    );

    modport slave (
        input  start, sample_valid, left, middle, right,
               plan_wr_en, plan_wr_addr, plan_wr_data,
        output m1_a, m1_b, m2_a, m2_b, dc1, dc2, node_count, busy, done, fault
    );
endinterface

// File: rtl/line_follow_sequencer.sv
// Debounced, plan-driven line-follow controller: steers on LFA samples, confirms
// junctions, and executes one turn-plan entry per confirmed node.
module line_follow_sequencer #(
    parameter logic [11:0] THRESH        = 12'd100,
    parameter int          NODE_SAMPLES  = 3,
    parameter int          CLEAR_SAMPLES = 4,
    parameter int          TURN_MIN      = 6,
    parameter int          LOST_SAMPLES  = 8,
    parameter int          PLAN_DEPTH    = 16
) (
    input  logic                   clk_50M,
    input  logic                   reset,
    line_follow_sequencer_if.slave bus
);
    localparam int IW = 4;
    localparam int CW = 8;

    typedef enum logic [2:0] {
        S_IDLE, S_FOLLOW, S_NODE, S_CLEAR, S_TURN, S_DONE, S_FAULT
    } state_e;

    typedef struct packed {
        logic       m1_a;
        logic       m1_b;
        logic       m2_a;
        logic       m2_b;
        logic [3:0] dc1;
        logic [3:0] dc2;
    } drive_t;

    localparam drive_t D_STOP   = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd0};
    localparam drive_t D_FWD    = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd11, 4'd11};
    localparam drive_t D_CORR_R = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd7,  4'd3};
    localparam drive_t D_CORR_L = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd7,  4'd3};
    localparam drive_t D_SPIN_L = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd7,  4'd7};
    localparam drive_t D_SPIN_R = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd7,  4'd7};

    state_e          state_q, state_d;
    drive_t          drive_q, drive_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   lost_q, lost_d;
    logic [3:0]      node_cnt_q, node_cnt_d;
    logic [IW-1:0]   plan_idx_q, plan_idx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            fault_q, fault_d;

    logic [1:0]      plan_mem [PLAN_DEPTH];
    logic [1:0]      plan_code;
    logic            plan_we;

    logic            sl, sm, sr;
    logic            all_on, all_off, centred;
    logic            smp;

    assign sl      = bus.left   > THRESH;
    assign sm      = bus.middle > THRESH;
    assign sr      = bus.right  > THRESH;
    assign all_on  = sl & sm & sr;
    assign all_off = ~sl & ~sm & ~sr;
    assign centred = ~sl & sm & ~sr;
    assign smp     = bus.sample_valid;

    // Plan memory is deliberately not reset: it survives a run abort.
    assign plan_we   = bus.plan_wr_en && (state_q == S_IDLE || state_q == S_DONE);
    assign plan_code = plan_mem[plan_idx_q];

    always_ff @(posedge clk_50M) begin
        if (plan_we) plan_mem[bus.plan_wr_addr] <= bus.plan_wr_data;
    end

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            drive_q    <= D_STOP;
            cnt_q      <= '0;
            lost_q     <= '0;
            node_cnt_q <= '0;
            plan_idx_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            drive_q    <= drive_d;
            cnt_q      <= cnt_d;
            lost_q     <= lost_d;
            node_cnt_q <= node_cnt_d;
            plan_idx_q <= plan_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fault_q    <= fault_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        drive_d    = drive_q;
        cnt_d      = cnt_q;
        lost_d     = lost_q;
        node_cnt_d = node_cnt_q;
        plan_idx_d = plan_idx_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                drive_d = D_STOP;
                // A sample arriving with start belongs to the previous run and is dropped.
                if (bus.start) begin
                    state_d    = S_FOLLOW;
                    node_cnt_d = '0;
                    plan_idx_d = '0;
                    cnt_d      = '0;
                    lost_d     = '0;
                end
            end

            S_FOLLOW: begin
                if (smp) begin
                    lost_d = all_off ? lost_q + 8'd1 : '0;
                    if (all_on) begin
                        state_d = S_NODE;
                        cnt_d   = 8'd1;
                        drive_d = D_FWD;
                    end else if (centred) begin
                        drive_d = D_FWD;
                    end else if (~sl & sm & sr) begin
                        drive_d = D_CORR_R;
                    end else if (sl & ~sm & ~sr) begin
                        drive_d = D_CORR_L;
                    end else if (all_off && (lost_q + 8'd1 == CW'(LOST_SAMPLES))) begin
                        state_d = S_FAULT;
                        drive_d = D_STOP;
                    end
                end
            end

            S_NODE: begin
                drive_d = D_FWD;
                if (smp) begin
                    if (!all_on) begin
                        state_d = S_FOLLOW;
                        cnt_d   = '0;
                        lost_d  = '0;
                    end else if (cnt_q + 8'd1 == CW'(NODE_SAMPLES)) begin
                        node_cnt_d = (node_cnt_q == 4'hF) ? node_cnt_q : node_cnt_q + 4'd1;
                        plan_idx_d = (plan_idx_q == IW'(PLAN_DEPTH - 1)) ? '0 : plan_idx_q + 4'd1;
                        cnt_d      = '0;
                        case (plan_code)
                            2'b00: begin state_d = S_CLEAR; drive_d = D_FWD;    end
                            2'b01: begin state_d = S_TURN;  drive_d = D_SPIN_L; end
                            2'b10: begin state_d = S_TURN;  drive_d = D_SPIN_R; end
                            default: begin state_d = S_DONE; drive_d = D_STOP;  end
                        endcase
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            S_CLEAR: begin
                drive_d = D_FWD;
                if (smp) begin
                    if (cnt_q + 8'd1 == CW'(CLEAR_SAMPLES)) begin
                        state_d = S_FOLLOW;
                        cnt_d   = '0;
                        lost_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            S_TURN: begin
                // Spin direction was latched at confirm; only the exit is decided here.
                if (smp) begin
                    if (cnt_q == CW'(TURN_MIN)) begin
                        if (centred) begin
                            state_d = S_FOLLOW;
                            drive_d = D_FWD;
                            cnt_d   = '0;
                            lost_d  = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            default: begin
                state_d = S_FAULT;
                drive_d = D_STOP;
            end
        endcase

        busy_d  = (state_d == S_FOLLOW) || (state_d == S_NODE) ||
                  (state_d == S_CLEAR)  || (state_d == S_TURN);
        done_d  = (state_d == S_DONE);
        fault_d = (state_d == S_FAULT);
    end

    assign bus.m1_a       = drive_q.m1_a;
    assign bus.m1_b       = drive_q.m1_b;
    assign bus.m2_a       = drive_q.m2_a;
    assign bus.m2_b       = drive_q.m2_b;
    assign bus.dc1        = drive_q.dc1;
    assign bus.dc2        = drive_q.dc2;
    assign bus.node_count = node_cnt_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.fault      = fault_q;
endmodule

// File: tb/tb_line_follow_sequencer.sv
// Directed bench for line_follow_sequencer: a per-sample behavioural model checked
// every cycle, plus literal expectations at key points of the run.
module tb_line_follow_sequencer;
    logic clk_50M;
    logic reset;

    line_follow_sequencer_if bus();

    line_follow_sequencer dut (
        .clk_50M (clk_50M),
        .reset   (reset),
        .bus     (bus)
    );

    initial clk_50M = 1'b0;
    always #10 clk_50M = ~clk_50M;

    int total = 0;
    int bad   = 0;

    // Model phases: what the robot is doing, not how the RTL encodes it.
    localparam int P_IDLE = 0, P_FOLLOW = 1, P_CONF = 2, P_CLEAR = 3,
                   P_TURN = 4, P_DONE = 5, P_FAULT = 6;
    localparam int D_STOP = 0, D_FWD = 1, D_CR = 2, D_CL = 3, D_SL = 4, D_SR = 5;

    typedef struct {
        int ph;
        int cnt;
        int lost;
        int nc;
        int idx;
        int drv;
    } mst_t;

    mst_t ms;
    int   plan_m [16];

    function automatic logic [11:0] drv_bits(int d);
        case (d)
            D_FWD:   return {4'b1010, 4'd11, 4'd11};
            D_CR:    return {4'b1001, 4'd7,  4'd3};
            D_CL:    return {4'b0010, 4'd7,  4'd3};
            D_SL:    return {4'b0110, 4'd7,  4'd7};
            D_SR:    return {4'b1001, 4'd7,  4'd7};
            default: return 12'h000;
        endcase
    endfunction

    function automatic logic [18:0] exp_vec(mst_t s);
        logic busy;
        busy = (s.ph == P_FOLLOW || s.ph == P_CONF || s.ph == P_CLEAR || s.ph == P_TURN);
        return {drv_bits(s.drv), 4'(s.nc), busy, s.ph == P_DONE, s.ph == P_FAULT};
    endfunction

    function automatic mst_t step(mst_t s, logic st, logic sv, logic [11:0] l, logic [11:0] m, logic [11:0] r);
        mst_t n;
        bit L, M, R, on, off, ctr;
        n = s;
        L = l > 12'd100; M = m > 12'd100; R = r > 12'd100;
        on = L && M && R; off = !L && !M && !R; ctr = !L && M && !R;
        case (s.ph)
            P_IDLE, P_DONE:
                if (st) begin n.ph = P_FOLLOW; n.nc = 0; n.idx = 0; n.lost = 0; n.cnt = 0; end
            P_FOLLOW: if (sv) begin
                n.lost = off ? s.lost + 1 : 0;
                if (on) begin n.ph = P_CONF; n.cnt = 1; n.drv = D_FWD; end
                else if (ctr) n.drv = D_FWD;
                else if (!L && M && R) n.drv = D_CR;
                else if (L && !M && !R) n.drv = D_CL;
                if (n.lost >= 8) begin n.ph = P_FAULT; n.drv = D_STOP; end
            end
            P_CONF: if (sv) begin
                if (!on) begin n.ph = P_FOLLOW; n.lost = 0; end
                else begin
                    n.cnt = s.cnt + 1;
                    if (n.cnt == 3) begin
                        n.nc  = (s.nc < 15) ? s.nc + 1 : 15;
                        n.idx = (s.idx + 1) % 16;
                        n.cnt = 0;
                        case (plan_m[s.idx])
                            0: begin n.ph = P_CLEAR; n.drv = D_FWD; end
                            1: begin n.ph = P_TURN;  n.drv = D_SL;  end
                            2: begin n.ph = P_TURN;  n.drv = D_SR;  end
                            default: begin n.ph = P_DONE; n.drv = D_STOP; end
                        endcase
                    end
                end
            end
            P_CLEAR: if (sv) begin
                n.cnt = s.cnt + 1;
                if (n.cnt == 4) begin n.ph = P_FOLLOW; n.lost = 0; end
            end
            P_TURN: if (sv) begin
                if (s.cnt >= 6 && ctr) begin n.ph = P_FOLLOW; n.drv = D_FWD; n.lost = 0; end
                n.cnt = s.cnt + 1;
            end
            default: ;
        endcase
        return n;
    endfunction

    always @(posedge clk_50M or posedge reset) begin
        if (reset) ms <= '{P_IDLE, 0, 0, 0, 0, D_STOP};
        else begin
            if (bus.plan_wr_en && (ms.ph == P_IDLE || ms.ph == P_DONE))
                plan_m[bus.plan_wr_addr] <= int'(bus.plan_wr_data);
            ms <= step(ms, bus.start, bus.sample_valid, bus.left, bus.middle, bus.right);
        end
    end

    logic [18:0] dut_v;
    assign dut_v = {bus.m1_a, bus.m1_b, bus.m2_a, bus.m2_b, bus.dc1, bus.dc2,
                    bus.node_count, bus.busy, bus.done, bus.fault};

    always @(negedge clk_50M) begin
        total++;
        if (dut_v !== exp_vec(ms)) begin
            bad++;
            $display("FAIL model_cmp t=%0t got=%b want=%b", $time, dut_v, exp_vec(ms));
        end
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk_50M); #1;
    endtask

    task automatic smp(int l, int m, int r);
        bus.sample_valid = 1'b1;
        bus.left = 12'(l); bus.middle = 12'(m); bus.right = 12'(r);
        cyc();
        bus.sample_valid = 1'b0;
        cyc();
    endtask

    task automatic smpn(int n, int l, int m, int r);
        repeat (n) smp(l, m, r);
    endtask

    task automatic go();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic wr(int a, int d);
        bus.plan_wr_en = 1'b1; bus.plan_wr_addr = 4'(a); bus.plan_wr_data = 2'(d);
        cyc();
        bus.plan_wr_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 0; bus.sample_valid = 0; bus.left = 0; bus.middle = 0; bus.right = 0;
        bus.plan_wr_en = 0; bus.plan_wr_addr = 0; bus.plan_wr_data = 0;
        repeat (3) cyc();
        chk("reset_outs", 32'(dut_v), 0);
        reset = 1'b0;
        cyc();

        wr(0, 1); wr(1, 0); wr(2, 2); wr(3, 3);

        // start with a coincident all-on strobe: that sample must not count
        bus.sample_valid = 1'b1; bus.left = 500; bus.middle = 500; bus.right = 500;
        go();
        bus.sample_valid = 1'b0;
        chk("start_flags", 32'(dut_v[2:0]), 3'b100);
        chk("start_drive", 32'(dut_v[18:7]), 12'h000);

        smpn(10, 50, 500, 50);
        chk("fwd", 32'(dut_v[18:7]), 12'hABB);
        chk("fwd_nc", 32'(dut_v[6:3]), 0);
        smp(50, 500, 500);   chk("corr_r", 32'(dut_v[18:7]), 12'h973);
        smp(500, 50, 50);    chk("corr_l", 32'(dut_v[18:7]), 12'h273);
        smp(500, 500, 50);   chk("hold_other", 32'(dut_v[18:7]), 12'h273);
        smp(100, 101, 100);  chk("thresh_strict", 32'(dut_v[18:7]), 12'hABB);

        smpn(2, 500, 500, 500); smp(50, 500, 50);
        chk("no_count", 32'(dut_v[6:3]), 0);

        smpn(3, 500, 500, 500);
        chk("node1_nc", 32'(dut_v[6:3]), 1);
        chk("spin_l", 32'(dut_v[18:7]), 12'h677);
        smpn(6, 50, 500, 50); chk("turn_min_hold", 32'(dut_v[18:7]), 12'h677);
        smp(50, 500, 50);     chk("reacquire", 32'(dut_v[18:7]), 12'hABB);

        smpn(3, 500, 500, 500);
        chk("node2_nc", 32'(dut_v[6:3]), 2);
        smpn(4, 500, 50, 50); chk("clear_fwd", 32'(dut_v[18:7]), 12'hABB);
        smp(500, 50, 50);     chk("after_clear", 32'(dut_v[18:7]), 12'h273);

        smpn(3, 500, 500, 500);
        chk("spin_r", 32'(dut_v[18:7]), 12'h977);
        smpn(6, 50, 500, 50); smp(50, 500, 50);

        smpn(3, 500, 500, 500);
        chk("done_flags", 32'(dut_v[2:0]), 3'b010);
        chk("done_nc", 32'(dut_v[6:3]), 4);
        chk("done_stop", 32'(dut_v[18:7]), 0);

        // second run restarts at plan[0]; writes and start while busy are ignored
        wr(0, 2);
        go();
        wr(0, 3);
        go();
        smpn(3, 500, 500, 500);
        chk("run2_nc", 32'(dut_v[6:3]), 1);
        chk("run2_spin_r", 32'(dut_v[18:7]), 12'h977);
        smpn(2, 50, 500, 50);

        #2 reset = 1'b1;
        #1 chk("async_reset", 32'(dut_v), 0);
        cyc();
        reset = 1'b0;
        cyc();

        go();
        smp(50, 500, 50);
        smpn(7, 10, 10, 10);
        chk("lost7_busy", 32'(dut_v[2:0]), 3'b100);
        chk("lost7_hold", 32'(dut_v[18:7]), 12'hABB);
        smp(50, 500, 50);
        smpn(7, 10, 10, 10);
        chk("lost_reset", 32'(dut_v[2:0]), 3'b100);
        smp(10, 10, 10);
        chk("fault_flags", 32'(dut_v[2:0]), 3'b001);
        chk("fault_stop", 32'(dut_v[18:7]), 0);
        go();
        cyc();
        chk("fault_start_ign", 32'(dut_v[2:0]), 3'b001);
        reset = 1'b1;
        cyc();
        chk("reset_clr_fault", 32'(dut_v[2:0]), 3'b000);
        reset = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
